// File: rtl/vending_pkg.sv
// -----------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the vending change dispenser: controller state
// encoding, coin values expressed in nickel units, default inventory caps and
// the default eject-acknowledge timeout.
// -----------------------------------------------------------------------------
package vending_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PICK    = 3'd1,
        EJECT_N = 3'd2,
        EJECT_D = 3'd3,
        FINISH  = 3'd4
    } state_t;

    // Coin values in nickel units (the unit of `amount` and `remaining`).
    localparam logic [3:0] NICKEL = 4'd1;
    localparam logic [3:0] DIME   = 4'd2;

    localparam int DEFAULT_NICKEL_CAP  = 20;
    localparam int DEFAULT_DIME_CAP    = 20;
    localparam int DEFAULT_ACK_TIMEOUT = 15;

endpackage

// File: rtl/vend_timeout.sv
// -----------------------------------------------------------------------------
// vend_timeout
// Counts consecutive cycles an eject request has gone unacknowledged.
// `expired` rises combinationally in the TIMEOUT-th consecutive `run` cycle so
// the controller can leave the eject state on that same clock edge.
//
// Ports:
//   clk      in   clock, posedge
//   rstn     in   synchronous active-low reset
//   clear    in   restart the count (not ejecting, or ack received)
//   run      in   one more cycle without acknowledge
//   expired  out  TIMEOUT consecutive run cycles reached (this cycle)
// -----------------------------------------------------------------------------
module vend_timeout #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int              CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    assign expired = run && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its inputs from before the edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear || expired) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/vending_change_dispenser.sv
// -----------------------------------------------------------------------------
// vending_change_dispenser
// Pays out change owed (in nickel units) using a greedy dime-first policy,
// one coin at a time through a handshake with the coin mechanism. Ends every
// request with a one-cycle `done` pulse; `short` reports unpaid change caused
// by an empty inventory or a mechanism that never acknowledged.
//
// Ports:
//   clk         in   clock, posedge
//   rstn        in   synchronous active-low reset
//   start       in   pay `amount`, sampled in IDLE only
//   amount[3:0] in   change owed in nickel units
//   refill      in   reload both inventories to cap, IDLE only, start wins
//   eject_ack   in   mechanism dropped the requested coin
//   eject_n     out  request one nickel (level, while in EJECT_N)
//   eject_d     out  request one dime (level, while in EJECT_D)
//   busy        out  controller not in IDLE
//   done        out  one-cycle completion pulse
//   short       out  change not fully paid, valid with done
//   remaining   out  nickel units still owed
//   nickel_cnt  out  nickels in stock
//   dime_cnt    out  dimes in stock
// -----------------------------------------------------------------------------
module vending_change_dispenser
    import vending_pkg::*;
#(
    parameter int NICKEL_CAP  = DEFAULT_NICKEL_CAP,
    parameter int DIME_CAP    = DEFAULT_DIME_CAP,
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [3:0] amount,
    input  logic       refill,
    input  logic       eject_ack,
    output logic       eject_n,
    output logic       eject_d,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [3:0] remaining,
    output logic [5:0] nickel_cnt,
    output logic [5:0] dime_cnt
);

    localparam logic [5:0] NICKEL_FULL = 6'(NICKEL_CAP);
    localparam logic [5:0] DIME_FULL   = 6'(DIME_CAP);

    state_t     state, state_next;
    logic [3:0] remaining_next;
    logic [5:0] nickel_next, dime_next;
    logic       short_q, short_next;

    logic       ejecting;
    logic       expired;

    assign ejecting = (state == EJECT_N) || (state == EJECT_D);

    vend_timeout #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (!ejecting || eject_ack),
        .run     (ejecting && !eject_ack),
        .expired (expired)
    );

    // NOTE: every variable is given its hold value before the case statement,
    // so no path through the block can leave it unassigned (no latches).
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        nickel_next    = nickel_cnt;
        dime_next      = dime_cnt;
        short_next     = short_q;

        case (state)
            IDLE: begin
                if (start) begin
                    remaining_next = amount;
                    short_next     = 1'b0;
                    state_next     = PICK;
                end else if (refill) begin
                    nickel_next = NICKEL_FULL;
                    dime_next   = DIME_FULL;
                end
            end

            PICK: begin
                if (remaining >= DIME && dime_cnt != '0) begin
                    state_next = EJECT_D;
                end else if (remaining >= NICKEL && nickel_cnt != '0) begin
                    state_next = EJECT_N;
                end else begin
                    // Nothing usable left: either fully paid or stuck short.
                    short_next = (remaining != '0);
                    state_next = FINISH;
                end
            end

            EJECT_D: begin
                if (eject_ack) begin
                    // Guards are redundant with PICK's selection but keep the
                    // counters safe from wrap-around under any input sequence.
                    dime_next      = (dime_cnt != '0) ? dime_cnt - 1'b1 : '0;
                    remaining_next = (remaining >= DIME) ? remaining - DIME : '0;
                    state_next     = PICK;
                end else if (expired) begin
                    short_next = 1'b1;
                    state_next = FINISH;
                end
            end

            EJECT_N: begin
                if (eject_ack) begin
                    nickel_next    = (nickel_cnt != '0) ? nickel_cnt - 1'b1 : '0;
                    remaining_next = (remaining >= NICKEL) ? remaining - NICKEL : '0;
                    state_next     = PICK;
                end else if (expired) begin
                    short_next = 1'b1;
                    state_next = FINISH;
                end
            end

            FINISH: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            remaining  <= '0;
            nickel_cnt <= NICKEL_FULL;
            dime_cnt   <= DIME_FULL;
            short_q    <= 1'b0;
        end else begin
            state      <= state_next;
            remaining  <= remaining_next;
            nickel_cnt <= nickel_next;
            dime_cnt   <= dime_next;
            short_q    <= short_next;
        end
    end

    // Moore outputs: decoded from the state register only.
    assign eject_n = (state == EJECT_N);
    assign eject_d = (state == EJECT_D);
    assign busy    = (state != IDLE);
    assign done    = (state == FINISH);
    assign short   = short_q;

endmodule
